// File: rtl/ram_op_loader_pkg.sv
// Shared constants and FSM encoding for the RAM operand loader.
// The widths match the ones used on the MU writeback path.
package ram_op_loader_pkg;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 8;
  localparam int LANES  = 4;
  localparam int RAM_W  = 32;
  localparam int GRP_W  = 6;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DRAIN   = 2'd2,
    PRESENT = 2'd3
  } state_e;

endpackage

// File: rtl/ram_op_loader_lane_bank.sv
// Four operand lane registers (MU1..MU4), written one lane at a time.
// The registers are not cleared between runs, so they keep the last group.
module op_lane_bank
  import ram_op_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_lane,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] op3,
  output logic [DATA_W-1:0] op4
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1 <= '0;
      op2 <= '0;
      op3 <= '0;
      op4 <= '0;
    end else if (wr_en) begin
      case (wr_lane)
        2'd0:    op1 <= wr_data;
        2'd1:    op2 <= wr_data;
        2'd2:    op3 <= wr_data;
        default: op4 <= wr_data;
      endcase
    end
  end

endmodule

// File: rtl/ram_op_loader.sv
// Fetches 4-word operand groups from the data RAM into the MU lane registers
// and offers each group to the MAC array over a valid/ready handshake.
module ram_op_loader
  import ram_op_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [GRP_W-1:0]  num_groups,
  output logic              ram_en,
  output logic [ADDR_W-1:0] address,
  input  logic [RAM_W-1:0]  dataRAM,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] op3,
  output logic [DATA_W-1:0] op4,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              busy,
  output logic              done,
  output state_e            dbg_state
);

  // Handshake: a group moves on any rising edge where op_valid and op_ready are
  // both high; op_valid never drops and op1..op4 never change until that edge.

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [GRP_W-1:0]   grp_q;
  logic               cap_en_q;
  logic [IDX_W-1:0]   cap_idx_q;
  logic               done_q;
  logic               unused_hi;

  assign unused_hi = ^dataRAM[RAM_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ram_en   = 1'b0;
    op_valid = 1'b0;
    case (state_q)
      IDLE:    if (start && (num_groups != '0)) state_d = READ;
      READ: begin
        ram_en = 1'b1;
        if (idx_q == 2'd3) state_d = DRAIN;
      end
      DRAIN:   state_d = PRESENT;
      PRESENT: begin
        op_valid = 1'b1;
        if (op_ready) state_d = (grp_q == 6'd1) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end

  // addr stops on the last word of a group so address holds it while ram_en
  // is low; the step to the next group's first word happens on the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      idx_q     <= '0;
      grp_q     <= '0;
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cap_en_q  <= ram_en;
      cap_idx_q <= idx_q;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (num_groups != '0) begin
              addr_q <= base_addr;
              grp_q  <= num_groups;
              idx_q  <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          idx_q <= idx_q + 2'd1;
          if (idx_q != 2'd3) addr_q <= addr_q + 8'd1;
        end
        PRESENT: begin
          if (op_ready) begin
            grp_q <= grp_q - 6'd1;
            if (grp_q == 6'd1) begin
              done_q <= 1'b1;
            end else begin
              idx_q  <= '0;
              addr_q <= addr_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  op_lane_bank u_lanes (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap_en_q),
    .wr_lane (cap_idx_q),
    .wr_data (dataRAM[DATA_W-1:0]),
    .op1     (op1),
    .op2     (op2),
    .op3     (op3),
    .op4     (op4)
  );

  assign address   = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
